hamming_rx_controller: RTL and testbench

Byte-stream controller that sequences the Hamming (8/4) decoder datapath. It collects the high and low codeword bytes from an upstream valid/ready stream and applies the 16-bit codeword to one hamming_decoder instance. It registers the decoded byte and its error flag and delivers them on a downstream valid/ready stream. It also keeps a saturating error count and a frame-boundary pulse for the receive path.

---
 rtl/hamming_pkg.sv | 6 +
 rtl/hamming_decoder.sv | 35 +++
 rtl/hamming_rx_controller.sv | 127 ++++++++++++
 tb/tb_hamming_rx_controller.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared types for the Hamming (8/4) receive path: FSM states and codeword/message widths.
package hamming_pkg;
  typedef enum logic [1:0] {S_HI, S_LO, S_OUT} rx_state_t;
  typedef logic [15:0] codeword_t;
  typedef logic [7:0]  msg_t;
endpackage

// File: rtl/hamming_decoder.sv
// Combinational Hamming (8/4) SECDED decoder: each codeword byte carries one nibble.
// Byte layout: bit0 = overall parity, bits[7:1] = Hamming(7,4) positions 1..7 (p1 p2 d0 p4 d1 d2 d3).
module hamming_decoder
  import hamming_pkg::*;
(
  input  codeword_t  codeword,
  output msg_t       msg,
  output logic [1:0] errors
);

  // Returns {error, nibble}; single-bit errors are corrected, any nonzero check flags an error.
  function automatic logic [4:0] dec_byte(input logic [7:0] b);
    logic [2:0] s;
    logic       par;
    logic [7:0] c;
    s[0] = b[1] ^ b[3] ^ b[5] ^ b[7];
    s[1] = b[2] ^ b[3] ^ b[6] ^ b[7];
    s[2] = b[4] ^ b[5] ^ b[6] ^ b[7];
    par  = ^b;
    c    = b;
    if (par) c[s] = ~c[s];
    return {(s != 3'd0) || par, c[7], c[6], c[5], c[3]};
  endfunction

  logic [4:0] dec_hi, dec_lo;

  always_comb begin
    dec_hi = dec_byte(codeword[15:8]);
    dec_lo = dec_byte(codeword[7:0]);
  end

  assign msg    = {dec_hi[3:0], dec_lo[3:0]};
  assign errors = {dec_hi[4], dec_lo[4]};

endmodule

// File: rtl/hamming_rx_controller.sv
// Sequences two-byte codewords from the input stream through hamming_decoder to a registered output stream.
// Optional: HAMMING_ERR_DROP_EN drops words with the error flag set instead of delivering them.
module hamming_rx_controller
  import hamming_pkg::*;
#(
  parameter int ERR_CNT_W = 8,
  parameter int FRAME_LEN = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           in_byte,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [7:0]           out_msg,
  output logic                 out_err,
  output logic                 out_valid,
  input  logic                 out_ready,
  input  logic                 clr_count,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 frame_done,
  output logic                 busy
);

  localparam int FC_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAME_LEN - 1);

  rx_state_t            state_q, state_d;
  msg_t                 hi_q, hi_d;
  msg_t                 out_msg_q, out_msg_d;
  logic                 out_err_q, out_err_d;
  logic                 out_valid_q, out_valid_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [FC_W-1:0]      frame_cnt_q, frame_cnt_d;
  logic                 frame_done_q, frame_done_d;

  msg_t       dec_msg;
  logic [1:0] dec_errors;
  logic       dec_err;
  logic       drop;

  hamming_decoder u_dec (
    .codeword ({hi_q, in_byte}),
    .msg      (dec_msg),
    .errors   (dec_errors)
  );

  assign dec_err = |dec_errors;

`ifdef HAMMING_ERR_DROP_EN
  assign drop = dec_err;
`else
  assign drop = 1'b0;
`endif

  assign in_ready = (state_q != S_OUT);

  always_comb begin
    state_d      = state_q;
    hi_d         = hi_q;
    out_msg_d    = out_msg_q;
    out_err_d    = out_err_q;
    out_valid_d  = out_valid_q;
    err_cnt_d    = err_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    frame_done_d = 1'b0;
    case (state_q)
      S_HI: if (in_valid) begin
        hi_d    = in_byte;
        state_d = S_LO;
      end
      S_LO: if (in_valid) begin
        if (dec_err && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
        if (drop) begin
          state_d = S_HI;
        end else begin
          out_msg_d   = dec_msg;
          out_err_d   = dec_err;
          out_valid_d = 1'b1;
          state_d     = S_OUT;
        end
      end
      S_OUT: if (out_ready) begin
        out_valid_d = 1'b0;
        state_d     = S_HI;
        if (frame_cnt_q == FC_LAST) begin
          frame_cnt_d  = '0;
          frame_done_d = 1'b1;
        end else begin
          frame_cnt_d = frame_cnt_q + 1'b1;
        end
      end
      default: state_d = S_HI;
    endcase
    // Clear wins over a same-cycle increment.
    if (clr_count) err_cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_HI;
      hi_q         <= '0;
      out_msg_q    <= '0;
      out_err_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      err_cnt_q    <= '0;
      frame_cnt_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hi_q         <= hi_d;
      out_msg_q    <= out_msg_d;
      out_err_q    <= out_err_d;
      out_valid_q  <= out_valid_d;
      err_cnt_q    <= err_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign out_msg    = out_msg_q;
  assign out_err    = out_err_q;
  assign out_valid  = out_valid_q;
  assign err_count  = err_cnt_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != S_HI);

endmodule

// File: tb/tb_hamming_rx_controller.sv
// Randomized self-checking bench for hamming_rx_controller (ERR_CNT_W=2, FRAME_LEN=4).
module tb_hamming_rx_controller;

`ifdef HAMMING_ERR_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif
  localparam int ECW = 2;
  localparam int FL  = 4;
  localparam int EMAX = 3;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [7:0]     in_byte = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [7:0]     out_msg;
  logic           out_err;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic           clr_count = 1'b0;
  logic [ECW-1:0] err_count;
  logic           frame_done;
  logic           busy;

  int pass_cnt = 0;
  int total_cnt = 0;
  int m_errs = 0;
  int m_frame = 0;

  always #5 clk = ~clk;

  hamming_rx_controller #(.ERR_CNT_W(ECW), .FRAME_LEN(FL)) dut (
    .clk(clk), .reset(reset), .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
    .out_msg(out_msg), .out_err(out_err), .out_valid(out_valid), .out_ready(out_ready),
    .clr_count(clr_count), .err_count(err_count), .frame_done(frame_done), .busy(busy)
  );

  function automatic logic [7:0] enc_nib(input logic [3:0] n);
    logic [7:0] b;
    b = '0;
    b[3] = n[0]; b[5] = n[1]; b[6] = n[2]; b[7] = n[3];
    b[1] = n[0] ^ n[1] ^ n[3];
    b[2] = n[0] ^ n[2] ^ n[3];
    b[4] = n[1] ^ n[2] ^ n[3];
    b[0] = ^b[7:1];
    return b;
  endfunction

  function automatic logic [15:0] enc_msg(input logic [7:0] m);
    return {enc_nib(m[7:4]), enc_nib(m[3:0])};
  endfunction

  // Nearest-codeword decode by exhaustive distance search.
  function automatic logic [4:0] model_byte(input logic [7:0] b);
    int best_d = 99;
    logic [3:0] best_n = '0;
    for (int n = 0; n < 16; n++) begin
      int d;
      d = $countones(enc_nib(4'(n)) ^ b);
      if (d < best_d) begin best_d = d; best_n = 4'(n); end
    end
    return {best_d != 0, best_n};
  endfunction

  function automatic logic [7:0] flip1(input logic [7:0] b, input int bit_i);
    logic [7:0] r;
    r = b;
    r[bit_i] = ~r[bit_i];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clr_count = 1'b0;
    tick(); tick();
    reset = 1'b0;
    m_errs = 0; m_frame = 0;
  endtask

  task automatic push_byte(input logic [7:0] b, input bit clr);
    int t = 0;
    in_byte = b; in_valid = 1'b1;
    while (!in_ready && t < 50) begin tick(); t++; end
    total_cnt++;
    if (!in_ready) $display("FAIL in_ready_timeout: got %b exp 1", in_ready); else pass_cnt++;
    clr_count = clr;
    tick();
    in_valid = 1'b0; clr_count = 1'b0;
  endtask

  task automatic xfer(input logic [15:0] cw, input int stall, input bit clr_on_lo);
    logic [4:0] mh, ml;
    logic [7:0] em;
    logic       ee;
    logic       efd;
    mh = model_byte(cw[15:8]);
    ml = model_byte(cw[7:0]);
    em = {mh[3:0], ml[3:0]};
    ee = mh[4] | ml[4];
    push_byte(cw[15:8], 1'b0);
    push_byte(cw[7:0], clr_on_lo);
    if (clr_on_lo) m_errs = 0;
    else if (ee && m_errs < EMAX) m_errs++;
    total_cnt++;
    if (err_count !== ECW'(m_errs)) $display("FAIL err_count: got %0d exp %0d", err_count, m_errs); else pass_cnt++;
    if (DROP && ee) begin
      total_cnt++;
      if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL drop_state: got vld=%b busy=%b exp 0 0", out_valid, busy); else pass_cnt++;
      return;
    end
    total_cnt++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) $display("FAIL out_valid_rise: got vld=%b rdy=%b exp 1 0", out_valid, in_ready); else pass_cnt++;
    total_cnt++;
    if (out_msg !== em || out_err !== ee) $display("FAIL out_data: got %h/%b exp %h/%b", out_msg, out_err, em, ee); else pass_cnt++;
    for (int i = 0; i < stall; i++) begin
      in_byte = 8'($urandom); in_valid = 1'b1;
      tick();
      total_cnt++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_msg !== em || out_err !== ee)
        $display("FAIL stall_hold: got vld=%b rdy=%b %h/%b exp 1 0 %h/%b", out_valid, in_ready, out_msg, out_err, em, ee);
      else pass_cnt++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    m_frame++;
    efd = (m_frame == FL);
    if (efd) m_frame = 0;
    total_cnt++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || frame_done !== efd)
      $display("FAIL handshake: got vld=%b busy=%b fd=%b exp 0 0 %b", out_valid, busy, frame_done, efd);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (frame_done !== 1'b0) $display("FAIL frame_done_width: got %b exp 0", frame_done); else pass_cnt++;
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++;
    if (out_valid !== 1'b0 || out_msg !== 8'h00 || out_err !== 1'b0 || err_count !== '0 ||
        frame_done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL reset_state: got vld=%b msg=%h err=%b cnt=%0d fd=%b busy=%b rdy=%b exp 0 00 0 0 0 0 1",
               out_valid, out_msg, out_err, err_count, frame_done, busy, in_ready);
    else pass_cnt++;
  endtask

  task automatic test_golden();
    xfer(enc_msg(8'hA5), 0, 1'b0);
  endtask

  task automatic test_single_flip();
    logic [15:0] cw;
    cw = enc_msg(8'hA5);
    cw[15:8] = flip1(cw[15:8], 6);
    xfer(cw, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    xfer(enc_msg(8'h5A), 5, 1'b0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 24; k++) begin
      logic [15:0] cw;
      cw = enc_msg(8'($urandom));
      if ($urandom_range(0, 1) == 1) cw[15:8] = flip1(cw[15:8], int'($urandom_range(0, 7)));
      if ($urandom_range(0, 1) == 1) cw[7:0]  = flip1(cw[7:0], int'($urandom_range(0, 7)));
      xfer(cw, int'($urandom_range(0, 2)), 1'b0);
    end
  endtask

  task automatic test_saturation();
    clr_count = 1'b1; tick(); clr_count = 1'b0;
    m_errs = 0;
    total_cnt++;
    if (err_count !== '0) $display("FAIL clr_idle: got %0d exp 0", err_count); else pass_cnt++;
    for (int k = 0; k < 5; k++) begin
      logic [15:0] cw;
      cw = enc_msg(8'($urandom));
      cw[7:0] = flip1(cw[7:0], int'($urandom_range(0, 7)));
      xfer(cw, 0, 1'b0);
    end
    begin
      logic [15:0] cw;
      cw = enc_msg(8'h77);
      cw[15:8] = flip1(cw[15:8], 0);
      xfer(cw, 0, 1'b1);
    end
  endtask

  task automatic test_frame();
    do_reset();
    for (int k = 0; k < 9; k++) xfer(enc_msg(8'($urandom)), int'($urandom_range(0, 1)), 1'b0);
  endtask

  task automatic test_reset_mid();
    do_reset();
    xfer(enc_msg(8'h11), 0, 1'b0);
    xfer(enc_msg(8'h22), 0, 1'b0);
    push_byte(8'h3C, 1'b0);
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL mid_busy: got %b exp 1", busy); else pass_cnt++;
    reset = 1'b1; tick(); reset = 1'b0;
    m_errs = 0; m_frame = 0;
    total_cnt++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || err_count !== '0)
      $display("FAIL mid_reset: got busy=%b vld=%b cnt=%0d exp 0 0 0", busy, out_valid, err_count);
    else pass_cnt++;
    for (int k = 0; k < FL; k++) xfer(enc_msg(8'($urandom)), 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_golden();
    test_single_flip();
    test_backpressure();
    test_random();
    test_saturation();
    test_frame();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
